apb_uart_completer: RTL and testbench

- APB completer that terminates the APB initiator's transfers and owns a UART: baud divisor, transmit data, status and receive data registers.
- It serializes transmit bytes onto uart_tx and deserializes uart_rx into a one-byte receive buffer.
- It is the peer of the APB initiator in the APB/UART subsystem; the block-level bench ties uart_tx to uart_rx for loopback.

---
 rtl/apb_uart_completer.sv | 222 ++++++++++++++++++++++
 tb/tb_apb_uart_completer.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_uart_completer.sv
// APB completer owning a UART: baud divisor, transmit, status and receive registers.
// Serializes TXDATA bytes onto uart_tx and deserializes uart_rx into a one-byte buffer.
module apb_uart_completer #(
  parameter int WIDTH    = 32,
  parameter int BAUD_RST = 16
) (
  input  logic             pclk,
  input  logic             preset,
  input  logic             psel,
  input  logic             penable,
  input  logic             pwrite,
  input  logic [WIDTH-1:0] paddr,
  input  logic [WIDTH-1:0] pwdata,
  output logic [WIDTH-1:0] prdata,
  output logic             pready,
  output logic             pslverr,
  input  logic             uart_rx,
  output logic             uart_tx
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_e;

  localparam logic [1:0]  A_BAUD    = 2'd0;
  localparam logic [1:0]  A_TXDATA  = 2'd1;
  localparam logic [1:0]  A_STATUS  = 2'd2;
  localparam logic [1:0]  A_RXDATA  = 2'd3;
  localparam logic [10:0] BAUD_MIN  = 11'd4;
  localparam logic [10:0] BAUD_INIT = 11'(BAUD_RST);

  uart_state_e tx_state, tx_next;
  uart_state_e rx_state, rx_next;

  logic [10:0] baud;
  logic [10:0] tx_baud, tx_cnt;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_byte;
  logic [10:0] rx_baud, rx_cnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_shift;
  logic        rx_s1, rx_s2, rx_prev;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_overrun;

  logic        access, addr_err, tx_busy, tx_stall;
  logic        wr, rd, tx_start, rx_read;
  logic [1:0]  reg_sel;
  logic        tx_bit_end, rx_bit_end, rx_mid, rx_fall, rx_store;
  logic        unused;

  assign unused = ^{pwdata[WIDTH-1:11], paddr[1:0]};

  // ---------------- APB decode ----------------
  assign access   = psel & penable & ~preset;
  assign addr_err = |paddr[WIDTH-1:4];
  assign reg_sel  = paddr[3:2];
  assign tx_busy  = (tx_state != S_IDLE);
  // A TXDATA write must not overwrite a byte still on the line, so it stalls.
  assign tx_stall = pwrite & ~addr_err & (reg_sel == A_TXDATA) & tx_busy;
  assign pready   = access & ~tx_stall;
  assign pslverr  = pready & addr_err;
  assign wr       = pready & pwrite & ~addr_err;
  assign rd       = pready & ~pwrite & ~addr_err;
  assign tx_start = wr & (reg_sel == A_TXDATA);
  assign rx_read  = rd & (reg_sel == A_RXDATA);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    prdata = '0;
    if (rd) begin
      case (reg_sel)
        A_BAUD:   prdata = WIDTH'(baud);
        A_STATUS: prdata = WIDTH'({rx_overrun, rx_valid, tx_busy});
        A_RXDATA: prdata = WIDTH'(rx_data);
        default:  prdata = '0;
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (preset) begin
      baud <= BAUD_INIT;
    end else if (wr && reg_sel == A_BAUD) begin
      baud <= (pwdata[10:0] < BAUD_MIN) ? BAUD_MIN : pwdata[10:0];
    end
  end

  // ---------------- TX FSM ----------------
  assign tx_bit_end = (tx_cnt == tx_baud - 11'd1);

  always_ff @(posedge pclk) begin
    if (preset) tx_state <= S_IDLE;
    else        tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      S_IDLE:  if (tx_start) tx_next = S_START;
      S_START: if (tx_bit_end) tx_next = S_DATA;
      S_DATA:  if (tx_bit_end && tx_bit == 3'd7) tx_next = S_STOP;
      S_STOP:  if (tx_bit_end) tx_next = S_IDLE;
      default: tx_next = S_IDLE;
    endcase
  end

  always_comb begin
    uart_tx = 1'b1;
    case (tx_state)
      S_START: uart_tx = 1'b0;
      S_DATA:  uart_tx = tx_byte[0];
      default: uart_tx = 1'b1;
    endcase
  end

  // Bit period is frozen at frame start so mid-frame BAUD writes apply to the next frame.
  always_ff @(posedge pclk) begin
    if (preset) begin
      tx_cnt  <= '0;
      tx_bit  <= '0;
      tx_byte <= '0;
      tx_baud <= BAUD_INIT;
    end else if (tx_state == S_IDLE) begin
      tx_cnt <= '0;
      tx_bit <= '0;
      if (tx_start) begin
        tx_byte <= pwdata[7:0];
        tx_baud <= baud;
      end
    end else if (tx_bit_end) begin
      tx_cnt <= '0;
      if (tx_state == S_DATA) begin
        tx_bit  <= tx_bit + 3'd1;
        tx_byte <= tx_byte >> 1;
      end
    end else begin
      tx_cnt <= tx_cnt + 11'd1;
    end
  end

  // ---------------- RX FSM ----------------
  always_ff @(posedge pclk) begin
    if (preset) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= uart_rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  assign rx_fall    = rx_prev & ~rx_s2;
  assign rx_mid     = (rx_cnt == (rx_baud >> 1));
  assign rx_bit_end = (rx_cnt == rx_baud - 11'd1);

  always_ff @(posedge pclk) begin
    if (preset) rx_state <= S_IDLE;
    else        rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      S_IDLE:  if (rx_fall) rx_next = S_START;
      S_START: if (rx_mid) rx_next = rx_s2 ? S_IDLE : S_DATA;
      S_DATA:  if (rx_bit_end && rx_bit == 3'd7) rx_next = S_STOP;
      S_STOP:  if (rx_bit_end) rx_next = S_IDLE;
      default: rx_next = S_IDLE;
    endcase
  end

  always_comb begin
    rx_store = (rx_state == S_STOP) & rx_bit_end & rx_s2;
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_baud  <= BAUD_INIT;
    end else begin
      case (rx_state)
        S_IDLE: begin
          rx_cnt <= '0;
          rx_bit <= '0;
          if (rx_fall) rx_baud <= baud;
        end
        S_START: rx_cnt <= rx_mid ? 11'd0 : rx_cnt + 11'd1;
        S_DATA: begin
          if (rx_bit_end) begin
            rx_cnt   <= '0;
            rx_bit   <= rx_bit + 3'd1;
            rx_shift <= {rx_s2, rx_shift[7:1]};
          end else begin
            rx_cnt <= rx_cnt + 11'd1;
          end
        end
        default: rx_cnt <= rx_cnt + 11'd1;
      endcase
    end
  end

  // A read racing a new byte returns the old byte and leaves only rx_valid set.
  always_ff @(posedge pclk) begin
    if (preset) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
    end else if (rx_store) begin
      rx_data    <= rx_shift;
      rx_valid   <= 1'b1;
      rx_overrun <= ~rx_read & (rx_valid | rx_overrun);
    end else if (rx_read) begin
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_apb_uart_completer.sv
// Self-checking bench for apb_uart_completer: register vector table, loopback
// sequences, injected glitch/framing frames and randomized frames vs. a queue model.
module tb_apb_uart_completer;
  localparam int WIDTH = 32;

  logic             pclk = 1'b0;
  logic             preset = 1'b1;
  logic             psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [WIDTH-1:0] paddr = '0, pwdata = '0;
  logic [WIDTH-1:0] prdata;
  logic             pready, pslverr;
  logic             uart_rx, uart_tx;
  logic             loop_en = 1'b1, rx_drv = 1'b1;

  assign uart_rx = loop_en ? uart_tx : rx_drv;

  apb_uart_completer #(.WIDTH(WIDTH), .BAUD_RST(16)) dut (
    .pclk(pclk), .preset(preset), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .uart_rx(uart_rx), .uart_tx(uart_tx)
  );

  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  int checks = 0, errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model pieces
  logic [7:0] tx_exp[$];
  logic [7:0] rx_exp[$];
  int         cur_baud = 16;
  logic       mon_en = 1'b0;

  function automatic int clamp_baud(input logic [31:0] v);
    int b;
    b = int'(v & 32'h7FF);
    return (b < 4) ? 4 : b;
  endfunction

  // One APB transfer; reports read data, error, wait states and the access cycle index.
  task automatic apb(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                     output logic [31:0] rdata, output logic err, output int waits,
                     output int acc_cyc);
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
    @(negedge pclk);
    penable = 1'b1;
    #1;
    waits = 0;
    while (pready !== 1'b1 && waits < 2000) begin
      @(negedge pclk);
      #1;
      waits++;
    end
    if (pready !== 1'b1) check("apb_pready_timeout", {31'b0, pready}, 32'd1);
    rdata   = prdata;
    err     = pslverr;
    acc_cyc = cyc;
    @(posedge pclk);
    #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic reg_rd(input logic [31:0] addr, output logic [31:0] data);
    logic e; int w, c;
    apb(1'b0, addr, 32'h0, data, e, w, c);
  endtask

  task automatic reg_wr(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] r; logic e; int w, c;
    apb(1'b1, addr, data, r, e, w, c);
  endtask

  task automatic tx_send(input logic [7:0] b, output int acc_cyc, output int waits);
    logic [31:0] r; logic e;
    apb(1'b1, 32'h4, {24'h0, b}, r, e, waits, acc_cyc);
    check("txdata_wr_err", {31'b0, e}, 32'd0);
    tx_exp.push_back(b);
    rx_exp.push_back(b);
  endtask

  // Polls STATUS back to back; tx_busy is high for 10*baud cycles after the accept cycle,
  // so with reads every second cycle the first idle read lands exactly 10*baud+2 later.
  task automatic wait_tx_idle(input int c0, input int bd, input string name,
                              output logic [31:0] st);
    logic [31:0] s; logic e; int w, k, n;
    n = 0;
    do begin
      apb(1'b0, 32'h8, 32'h0, s, e, w, k);
      n++;
    end while (s[0] && n < 4000);
    check({name, "_busy_fall"}, k - c0, 10 * bd + 2);
    st = s;
  endtask

  task automatic wait_rx(input string name);
    logic [31:0] s;
    int n;
    n = 0;
    do begin
      reg_rd(32'h8, s);
      n++;
    end while (!s[1] && n < 300);
    check({name, "_rx_valid"}, {31'b0, s[1]}, 32'd1);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int bd);
    @(negedge pclk);
    rx_drv = 1'b0;
    repeat (bd) @(negedge pclk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      repeat (bd) @(negedge pclk);
    end
    rx_drv = stop_bit;
    repeat (bd) @(negedge pclk);
    rx_drv = 1'b1;
    repeat (bd) @(negedge pclk);
  endtask

  // Independent decoder of uart_tx, sampling mid-bit.
  initial begin
    forever begin
      @(negedge pclk);
      if (mon_en && uart_tx === 1'b0) begin
        logic [7:0] b;
        int bd;
        bd = cur_baud;
        repeat (bd / 2) @(negedge pclk);
        check("tx_start_bit", {31'b0, uart_tx}, 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (bd) @(negedge pclk);
          b[i] = uart_tx;
        end
        repeat (bd) @(negedge pclk);
        check("tx_stop_bit", {31'b0, uart_tx}, 32'd1);
        if (tx_exp.size() == 0) check("tx_frame_expected", tx_exp.size(), 32'd1);
        else check("tx_frame_byte", {24'h0, b}, {24'h0, tx_exp.pop_front()});
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err, input string name);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.name = name;
    vecs.push_back(v);
  endtask

  initial begin
    logic [31:0] r, st;
    logic        e;
    int          w, c, c1, c2;

    // Reset state
    repeat (3) @(posedge pclk);
    #1 preset = 1'b0;
    @(negedge pclk);
    check("rst_uart_tx", {31'b0, uart_tx}, 32'd1);
    check("rst_pready", {31'b0, pready}, 32'd0);
    check("rst_pslverr", {31'b0, pslverr}, 32'd0);
    check("rst_prdata", prdata, 32'd0);

    // Register vector table
    add_vec(1'b0, 32'h0,        32'h0,        32'd16,    1'b0, "baud_reset");
    add_vec(1'b0, 32'h8,        32'h0,        32'd0,     1'b0, "status_reset");
    add_vec(1'b0, 32'hC,        32'h0,        32'd0,     1'b0, "rxdata_reset");
    add_vec(1'b0, 32'h4,        32'h0,        32'd0,     1'b0, "txdata_read");
    add_vec(1'b1, 32'h0,        32'd1,        32'd0,     1'b0, "baud_wr_1");
    add_vec(1'b0, 32'h0,        32'h0,        32'd4,     1'b0, "baud_clamp_1");
    add_vec(1'b1, 32'h0,        32'hFFFFF803, 32'd0,     1'b0, "baud_wr_hi3");
    add_vec(1'b0, 32'h0,        32'h0,        32'd4,     1'b0, "baud_clamp_3");
    add_vec(1'b1, 32'h0,        32'h7FF,      32'd0,     1'b0, "baud_wr_max");
    add_vec(1'b0, 32'h0,        32'h0,        32'h7FF,   1'b0, "baud_max");
    add_vec(1'b1, 32'h0,        32'd5,        32'd0,     1'b0, "baud_wr_5");
    add_vec(1'b1, 32'h8,        32'hFF,       32'd0,     1'b0, "status_wr");
    add_vec(1'b0, 32'h8,        32'h0,        32'd0,     1'b0, "status_after_wr");
    add_vec(1'b0, 32'h10,       32'h0,        32'd0,     1'b1, "err_rd_10");
    add_vec(1'b1, 32'h20,       32'd9,        32'd0,     1'b1, "err_wr_20");
    add_vec(1'b0, 32'hFFFFFFF0, 32'h0,        32'd0,     1'b1, "err_rd_hi");
    add_vec(1'b0, 32'h3,        32'h0,        32'd5,     1'b0, "baud_low_bits");
    add_vec(1'b1, 32'h0,        32'd66,       32'd0,     1'b0, "baud_wr_66");
    add_vec(1'b0, 32'h0,        32'h0,        32'd66,    1'b0, "baud_66");
    foreach (vecs[i]) begin
      apb(vecs[i].wr, vecs[i].addr, vecs[i].wdata, r, e, w, c);
      check({vecs[i].name, "_rdata"}, r, vecs[i].exp_rdata);
      check({vecs[i].name, "_err"}, {31'b0, e}, {31'b0, vecs[i].exp_err});
      check({vecs[i].name, "_waits"}, w, 32'd0);
    end
    cur_baud = 66;

    // Reset in the middle of a frame
    reg_wr(32'h4, 32'h5A);
    repeat (20) @(negedge pclk);
    check("midframe_tx_low", {31'b0, uart_tx}, 32'd0);
    preset = 1'b1;
    @(negedge pclk);
    check("midframe_rst_tx_idle", {31'b0, uart_tx}, 32'd1);
    repeat (2) @(negedge pclk);
    preset = 1'b0;
    reg_rd(32'h8, r);
    check("midframe_rst_status", r, 32'd0);
    reg_rd(32'h0, r);
    check("midframe_rst_baud", r, 32'd16);
    reg_wr(32'h0, 32'd66);
    mon_en = 1'b1;

    // Basic loopback
    tx_send(8'h56, c, w);
    wait_tx_idle(c, 66, "basic", st);
    check("basic_status_at_fall", st, 32'h2);
    reg_rd(32'hC, r);
    check("basic_rxdata", r, {24'h0, rx_exp.pop_front()});
    reg_rd(32'h8, r);
    check("basic_status_clear", r, 32'd0);

    // Back-to-back writes: second stalls until the first frame ends
    tx_send(8'd14, c1, w);
    tx_send(8'd78, c2, w);
    check("b2b_wait_states", w, 10 * 66 - 1);
    reg_rd(32'hC, r);
    check("b2b_rx_first", r, {24'h0, rx_exp.pop_front()});
    reg_rd(32'h8, r);
    check("b2b_status_busy", r, 32'h1);
    wait_tx_idle(c2, 66, "b2b", st);
    check("b2b_status_at_fall", st, 32'h2);
    reg_rd(32'hC, r);
    check("b2b_rx_second", r, {24'h0, rx_exp.pop_front()});

    // Overrun: second byte overwrites the unread first one
    tx_send(8'd99, c1, w);
    tx_send(8'hA5, c2, w);
    void'(rx_exp.pop_front());
    wait_tx_idle(c2, 66, "ovr", st);
    check("ovr_status", st, 32'h6);
    reg_rd(32'hC, r);
    check("ovr_rxdata", r, {24'h0, rx_exp.pop_front()});
    reg_rd(32'h8, r);
    check("ovr_status_clear", r, 32'd0);

    // Glitch and framing error with an external line
    loop_en = 1'b0;
    repeat (4) @(negedge pclk);
    rx_drv = 1'b0;
    repeat (66 / 4) @(negedge pclk);
    rx_drv = 1'b1;
    repeat (200) @(negedge pclk);
    reg_rd(32'h8, r);
    check("glitch_status", r, 32'd0);
    send_frame(8'h3C, 1'b0, 66);
    reg_rd(32'h8, r);
    check("framing_status", r, 32'd0);
    send_frame(8'hC3, 1'b1, 66);
    reg_rd(32'h8, r);
    check("inject_good_status", r, 32'h2);
    reg_rd(32'hC, r);
    check("inject_good_rxdata", r, 32'hC3);
    loop_en = 1'b1;
    repeat (4) @(negedge pclk);

    // Randomized frames and register accesses
    for (int n = 0; n < 6; n++) begin
      logic [31:0] bv, addr;
      logic [7:0]  b;
      int          eb;
      bv = ($urandom & 32'hFFFFF800) | 32'($urandom_range(0, 24));
      eb = clamp_baud(bv);
      reg_wr(32'h0, bv);
      reg_rd(32'h0, r);
      check("rnd_baud", r, eb);
      cur_baud = eb;
      b = 8'($urandom);
      tx_send(b, c, w);
      wait_tx_idle(c, eb, "rnd", st);
      wait_rx("rnd");
      reg_rd(32'hC, r);
      check("rnd_rxdata", r, {24'h0, rx_exp.pop_front()});
      addr = $urandom;
      if (addr[31:4] == 28'h0) addr[4] = 1'b1;
      apb(1'b0, addr, 32'h0, r, e, w, c);
      check("rnd_err_flag", {31'b0, e}, 32'd1);
      check("rnd_err_rdata", r, 32'd0);
      check("rnd_err_waits", w, 32'd0);
    end

    repeat (50) @(negedge pclk);
    check("tx_frames_drained", tx_exp.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
